frame_sync_controller: RTL and testbench

//   Frame-synchronisation controller wrapped around an error-tolerant serial sync-word correlator.
//   - Hunts for the 12-bit sync word 111000101011, accepting up to ERR_TOL bit errors.
//   - Confirms the frame period, then flywheels through missed sync words.
//   - Emits payload bits with their in-frame index. Sits between the serial bit receiver and the deframer.

---
 rtl/frame_sync_controller_pkg.sv | 18 +
 rtl/frame_sync_controller_if.sv | 33 +++
 rtl/frame_sync_controller_sync_correlator.sv | 47 ++++
 rtl/frame_sync_controller.sv | 167 ++++++++++++++++
 tb/tb_frame_sync_controller.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_sync_controller_pkg.sv
// Shared definitions for the frame-sync controller: FSM state encoding and default
// sync-word / framing constants.
package frame_sync_controller_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam int                   DEF_WIDTH       = 12;
    localparam logic [DEF_WIDTH-1:0] DEF_PATTERN     = 12'b111000101011;
    localparam int                   DEF_ERR_TOL     = 2;
    localparam int                   DEF_FRAME_LEN   = 64;
    localparam int                   DEF_CONFIRM_CNT = 3;
    localparam int                   DEF_LOSS_CNT    = 4;

endpackage

// File: rtl/frame_sync_controller_if.sv
// Bit-stream interface between the serial receiver (master) and the frame-sync
// controller (slave), including the framed payload and status outputs.
interface frame_sync_controller_if
    import frame_sync_controller_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
);
    logic                           i_data;
    logic                           i_valid;
    logic                           i_resync;
    logic [1:0]                     o_state;
    logic                           o_locked;
    logic                           o_frame_start;
    logic                           o_sync_lost;
    logic [$clog2(WIDTH+1)-1:0]     o_err_bits;
    logic                           o_data;
    logic                           o_data_valid;
    logic [$clog2(FRAME_LEN)-1:0]   o_bit_idx;

    modport master (
        output i_data, i_valid, i_resync,
        input  o_state, o_locked, o_frame_start, o_sync_lost, o_err_bits,
               o_data, o_data_valid, o_bit_idx
    );

    modport slave (
        input  i_data, i_valid, i_resync,
        output o_state, o_locked, o_frame_start, o_sync_lost, o_err_bits,
               o_data, o_data_valid, o_bit_idx
    );

endinterface

// File: rtl/frame_sync_controller_sync_correlator.sv
// Serial sync-word correlator: shift window, fill counter and mismatch popcount.
// errs/hit describe the window as it will be after the current bit is shifted in.
module frame_sync_controller_sync_correlator
    import frame_sync_controller_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = DEF_PATTERN,
    parameter int               ERR_TOL = DEF_ERR_TOL,
    localparam int              ERR_W   = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             data_in,
    output logic [ERR_W-1:0] errs,
    output logic             hit
);
    localparam int FILL_W = $clog2(WIDTH+1);

    logic [WIDTH-1:0]  win_q, win_d, win_next;
    logic [FILL_W-1:0] fill_q, fill_d;

    always_comb begin
        win_next = {win_q[WIDTH-2:0], data_in};
        errs     = ERR_W'($countones(win_next ^ PATTERN));
        // fill counts bits before this one, so WIDTH-1 means this bit completes the window
        hit      = (fill_q >= FILL_W'(WIDTH-1)) && (errs <= ERR_W'(ERR_TOL));
        win_d    = win_q;
        fill_d   = fill_q;
        if (shift_en) begin
            win_d = win_next;
            if (fill_q != FILL_W'(WIDTH))
                fill_d = fill_q + FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/frame_sync_controller.sv
// Frame-sync controller: HUNT/CONFIRM/LOCKED acquisition with flywheel, frame bit
// counter and registered payload/status outputs around the sync correlator.
module frame_sync_controller
    import frame_sync_controller_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN     = DEF_PATTERN,
    parameter int               ERR_TOL     = DEF_ERR_TOL,
    parameter int               FRAME_LEN   = DEF_FRAME_LEN,
    parameter int               CONFIRM_CNT = DEF_CONFIRM_CNT,
    parameter int               LOSS_CNT    = DEF_LOSS_CNT
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    frame_sync_controller_if.slave   bus
);
    localparam int ERR_W  = $clog2(WIDTH+1);
    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam int CONF_W = $clog2(CONFIRM_CNT+1);
    localparam int MISS_W = $clog2(LOSS_CNT+1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CONF_W-1:0] conf_cnt_q, conf_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic              locked_q, locked_d;
    logic              frame_start_q, frame_start_d;
    logic              sync_lost_q, sync_lost_d;
    logic [ERR_W-1:0]  err_bits_q, err_bits_d;
    logic              data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;

    logic              accept;
    logic              sync_pos;
    logic              hit;
    logic [ERR_W-1:0]  errs;

    // A resync cycle drops its bit entirely, window included.
    assign accept   = bus.i_valid && !bus.i_resync;
    assign sync_pos = (bit_cnt_q == IDX_W'(FRAME_LEN-1));

    frame_sync_controller_sync_correlator #(
        .WIDTH   (WIDTH),
        .PATTERN (PATTERN),
        .ERR_TOL (ERR_TOL)
    ) u_sync_correlator (
        .clk      (i_clk),
        .rst      (i_reset),
        .shift_en (accept),
        .data_in  (bus.i_data),
        .errs     (errs),
        .hit      (hit)
    );

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        conf_cnt_d    = conf_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        err_bits_d    = err_bits_q;
        data_d        = data_q;
        bit_idx_d     = bit_idx_q;
        frame_start_d = 1'b0;
        sync_lost_d   = 1'b0;
        data_valid_d  = 1'b0;

        if (bus.i_resync) begin
            state_d    = ST_HUNT;
            bit_cnt_d  = '0;
            conf_cnt_d = '0;
            miss_cnt_d = '0;
            err_bits_d = '0;
            data_d     = 1'b0;
            bit_idx_d  = '0;
        end else if (bus.i_valid) begin
            bit_cnt_d = sync_pos ? '0 : bit_cnt_q + IDX_W'(1);
            unique case (state_q)
                ST_HUNT: begin
                    if (hit) begin
                        state_d       = (CONFIRM_CNT == 1) ? ST_LOCKED : ST_CONFIRM;
                        conf_cnt_d    = CONF_W'(1);
                        miss_cnt_d    = '0;
                        bit_cnt_d     = '0;
                        frame_start_d = 1'b1;
                        err_bits_d    = errs;
                    end
                end
                ST_CONFIRM: begin
                    if (sync_pos) begin
                        err_bits_d = errs;
                        if (hit) begin
                            conf_cnt_d    = conf_cnt_q + CONF_W'(1);
                            frame_start_d = 1'b1;
                            if (conf_cnt_q == CONF_W'(CONFIRM_CNT-1)) begin
                                state_d    = ST_LOCKED;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            state_d    = ST_HUNT;
                            conf_cnt_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (sync_pos) begin
                        err_bits_d = errs;
                        if (hit) begin
                            miss_cnt_d    = '0;
                            frame_start_d = 1'b1;
                        end else if (miss_cnt_q == MISS_W'(LOSS_CNT-1)) begin
                            state_d     = ST_HUNT;
                            miss_cnt_d  = '0;
                            sync_lost_d = 1'b1;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end else if (bit_cnt_q <= IDX_W'(FRAME_LEN-WIDTH-1)) begin
                        data_valid_d = 1'b1;
                        data_d       = bus.i_data;
                        bit_idx_d    = bit_cnt_q;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_HUNT;
            bit_cnt_q     <= '0;
            conf_cnt_q    <= '0;
            miss_cnt_q    <= '0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_lost_q   <= 1'b0;
            err_bits_q    <= '0;
            data_q        <= 1'b0;
            data_valid_q  <= 1'b0;
            bit_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            conf_cnt_q    <= conf_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            sync_lost_q   <= sync_lost_d;
            err_bits_q    <= err_bits_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            bit_idx_q     <= bit_idx_d;
        end
    end

    assign bus.o_state       = state_q;
    assign bus.o_locked      = locked_q;
    assign bus.o_frame_start = frame_start_q;
    assign bus.o_sync_lost   = sync_lost_q;
    assign bus.o_err_bits    = err_bits_q;
    assign bus.o_data        = data_q;
    assign bus.o_data_valid  = data_valid_q;
    assign bus.o_bit_idx     = bit_idx_q;

endmodule

// File: tb/tb_frame_sync_controller.sv
// Bench for frame_sync_controller: randomized framed streams checked every cycle
// against a bit-history reference model, plus scenario checkpoints.
module tb_frame_sync_controller;

    localparam int WIDTH       = 12;
    localparam int ERR_TOL     = 2;
    localparam int FRAME_LEN   = 64;
    localparam int CONFIRM_CNT = 3;
    localparam int LOSS_CNT    = 4;
    localparam int PAY_LEN     = FRAME_LEN - WIDTH;

    logic clk = 1'b0;
    logic i_reset;
    logic [WIDTH-1:0] pat = 12'b111000101011;

    int n_chk = 0;
    int n_err = 0;

    frame_sync_controller_if #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) bus ();

    frame_sync_controller #(
        .WIDTH       (WIDTH),
        .PATTERN     (12'b111000101011),
        .ERR_TOL     (ERR_TOL),
        .FRAME_LEN   (FRAME_LEN),
        .CONFIRM_CNT (CONFIRM_CNT),
        .LOSS_CNT    (LOSS_CNT)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: last WIDTH accepted bits, frame position, acquisition mode
    bit q_hist[$];
    int m_mode;      // 0 hunting, 1 confirming, 2 locked
    int m_pos;       // bits accepted since the last sync word ended
    int m_hits, m_misses;
    int exp_state, exp_fs, exp_sl, exp_err, exp_d, exp_dv, exp_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int window_errs();
        int e   = 0;
        int off = WIDTH - q_hist.size();
        for (int i = 0; i < WIDTH; i++) begin
            bit w;
            w = (i < off) ? 1'b0 : q_hist[i - off];
            if (w != pat[WIDTH-1-i]) e++;
        end
        return e;
    endfunction

    task automatic model_step(input bit rst, input bit vld, input bit rsy, input bit d);
        int  e;
        bit  hit, at_sync, payload;
        int  pos_now;
        exp_fs = 0; exp_sl = 0; exp_dv = 0;
        if (rst) begin
            q_hist.delete();
            m_mode = 0; m_pos = 0; m_hits = 0; m_misses = 0;
            exp_err = 0; exp_d = 0; exp_idx = 0;
        end else if (rsy) begin
            m_mode = 0; m_pos = 0; m_hits = 0; m_misses = 0;
            exp_err = 0; exp_d = 0; exp_idx = 0;
        end else if (vld) begin
            q_hist.push_back(d);
            if (q_hist.size() > WIDTH) void'(q_hist.pop_front());
            e       = window_errs();
            hit     = (q_hist.size() == WIDTH) && (e <= ERR_TOL);
            pos_now = m_pos;
            at_sync = (pos_now == FRAME_LEN - 1);
            payload = (m_mode == 2) && (pos_now < PAY_LEN);
            m_pos   = at_sync ? 0 : pos_now + 1;
            if (m_mode == 0) begin
                if (hit) begin
                    m_mode = (CONFIRM_CNT == 1) ? 2 : 1;
                    m_hits = 1; m_misses = 0; m_pos = 0;
                    exp_fs = 1; exp_err = e;
                end
            end else if (at_sync) begin
                exp_err = e;
                if (m_mode == 1) begin
                    if (hit) begin
                        m_hits++; exp_fs = 1;
                        if (m_hits == CONFIRM_CNT) begin m_mode = 2; m_misses = 0; end
                    end else m_mode = 0;
                end else begin
                    if (hit) begin m_misses = 0; exp_fs = 1; end
                    else begin
                        m_misses++;
                        if (m_misses == LOSS_CNT) begin m_mode = 0; exp_sl = 1; end
                    end
                end
            end
            if (payload) begin exp_dv = 1; exp_d = d; exp_idx = pos_now; end
        end
        exp_state = m_mode;
    endtask

    task automatic cycle(input bit rst, input bit vld, input bit rsy, input bit d);
        model_step(rst, vld, rsy, d);
        i_reset      = rst;
        bus.i_valid  = vld;
        bus.i_resync = rsy;
        bus.i_data   = d;
        @(posedge clk);
        #1;
        chk("state",       32'(bus.o_state),       32'(exp_state));
        chk("locked",      32'(bus.o_locked),      32'(exp_state == 2));
        chk("frame_start", 32'(bus.o_frame_start), 32'(exp_fs));
        chk("sync_lost",   32'(bus.o_sync_lost),   32'(exp_sl));
        chk("err_bits",    32'(bus.o_err_bits),    32'(exp_err));
        chk("data_valid",  32'(bus.o_data_valid),  32'(exp_dv));
        if (exp_dv != 0 || rst || rsy) begin
            chk("data",    32'(bus.o_data),    32'(exp_d));
            chk("bit_idx", 32'(bus.o_bit_idx), 32'(exp_idx));
        end
    endtask

    task automatic send_bit(input bit d, input int gap_pct);
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
            cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(1)));
        cycle(1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int gap_pct);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], gap_pct);
    endtask

    task automatic send_fill(input int n, input int gap_pct, input bit rnd);
        for (int i = 0; i < n; i++) send_bit(rnd ? 1'($urandom_range(1)) : 1'b0, gap_pct);
    endtask

    function automatic logic [WIDTH-1:0] err_mask(input int n);
        logic [WIDTH-1:0] m = '0;
        while ($countones(m) < n) m[$urandom_range(WIDTH-1)] = 1'b1;
        return m;
    endfunction

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        i_reset = 1'b1; bus.i_valid = 1'b0; bus.i_resync = 1'b0; bus.i_data = 1'b0;

        // Reset state
        do_reset();
        chk("rst_state",  32'(bus.o_state),      32'd0);
        chk("rst_dvalid", 32'(bus.o_data_valid), 32'd0);
        chk("rst_err",    32'(bus.o_err_bits),   32'd0);

        // Clean stream: acquisition after three syncs, then flywheel payload
        send_fill(12 + $urandom_range(18), 0, 1'b0);
        for (int f = 0; f < 5; f++) begin
            send_word(pat, 0);
            chk("clean_fs", 32'(bus.o_frame_start), 32'd1);
            if (f < 2) chk("clean_confirm", 32'(bus.o_state), 32'd1);
            if (f == 2) chk("clean_locked", 32'(bus.o_locked), 32'd1);
            send_fill(PAY_LEN, 0, 1'b1);
        end

        // Error tolerance while locked
        send_word(pat ^ err_mask(2), 0);
        chk("tol2_err", 32'(bus.o_err_bits), 32'd2);
        chk("tol2_fs",  32'(bus.o_frame_start), 32'd1);
        send_fill(PAY_LEN, 0, 1'b1);
        send_word(pat ^ err_mask(3), 0);
        chk("tol3_err",    32'(bus.o_err_bits),    32'd3);
        chk("tol3_fs",     32'(bus.o_frame_start), 32'd0);
        chk("tol3_locked", 32'(bus.o_locked),      32'd1);
        send_bit(1'($urandom_range(1)), 0);
        chk("tol3_payload", 32'(bus.o_data_valid), 32'd1);
        chk("tol3_idx0",    32'(bus.o_bit_idx),    32'd0);
        send_fill(PAY_LEN - 1, 0, 1'b1);
        send_word(pat, 0);
        send_fill(PAY_LEN, 0, 1'b1);

        // Four consecutive missed syncs drop lock
        for (int f = 0; f < LOSS_CNT; f++) begin
            send_word(pat ^ err_mask(3 + $urandom_range(2)), 0);
            if (f < LOSS_CNT - 1) begin
                chk("flywheel_locked", 32'(bus.o_locked), 32'd1);
                send_fill(PAY_LEN, 0, 1'b1);
            end
        end
        chk("loss_pulse", 32'(bus.o_sync_lost), 32'd1);
        chk("loss_state", 32'(bus.o_state),     32'd0);
        send_bit(1'($urandom_range(1)), 0);
        chk("loss_nopay", 32'(bus.o_data_valid), 32'd0);

        // Miss during CONFIRM, then re-acquire at a shifted position
        do_reset();
        send_fill(15, 0, 1'b0);
        send_word(pat, 0);
        send_fill(PAY_LEN, 0, 1'b1);
        send_word('0, 0);
        chk("confirm_miss_state", 32'(bus.o_state),    32'd0);
        chk("confirm_miss_err",   32'(bus.o_err_bits), 32'($countones(pat)));
        send_fill(37, 0, 1'b0);
        send_word(pat, 0);
        chk("shift_confirm", 32'(bus.o_state),       32'd1);
        chk("shift_fs",      32'(bus.o_frame_start), 32'd1);
        for (int f = 0; f < 2; f++) begin
            send_fill(PAY_LEN, 0, 1'b1);
            send_word(pat, 0);
        end
        chk("shift_locked", 32'(bus.o_locked), 32'd1);
        send_fill(PAY_LEN, 0, 1'b1);

        // Sparse strobes behave like the dense stream
        do_reset();
        send_fill(20, 50, 1'b0);
        for (int f = 0; f < 5; f++) begin
            send_word(pat, 50);
            if (f == 2) chk("sparse_locked", 32'(bus.o_locked), 32'd1);
            send_fill(PAY_LEN, 50, 1'b1);
        end

        // Resync while locked; window survives so the next bit can complete a sync
        do_reset();
        send_fill(14, 0, 1'b0);
        for (int f = 0; f < 3; f++) begin send_word(pat, 0); send_fill(PAY_LEN, 0, 1'b0); end
        chk("g_locked", 32'(bus.o_locked), 32'd1);
        send_fill(20, 0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        chk("resync_state",  32'(bus.o_state),      32'd0);
        chk("resync_dvalid", 32'(bus.o_data_valid), 32'd0);
        chk("resync_err",    32'(bus.o_err_bits),   32'd0);
        send_fill(32, 0, 1'b0);
        for (int i = WIDTH - 1; i >= 1; i--) send_bit(pat[i], 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        send_bit(pat[0], 0);
        chk("resync_reacq", 32'(bus.o_state),       32'd1);
        chk("resync_fs",    32'(bus.o_frame_start), 32'd1);
        for (int f = 0; f < 2; f++) begin send_fill(PAY_LEN, 0, 1'b0); send_word(pat, 0); end
        chk("resync_relock", 32'(bus.o_locked), 32'd1);

        // Reset mid-frame, then relock
        send_fill(25, 0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        chk("midrst_state",  32'(bus.o_state),      32'd0);
        chk("midrst_dvalid", 32'(bus.o_data_valid), 32'd0);
        send_fill(10, 0, 1'b0);
        for (int f = 0; f < 3; f++) begin send_word(pat, 0); send_fill(PAY_LEN, 0, 1'b1); end
        chk("midrst_relock", 32'(bus.o_locked), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
